pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencer for the 16x16 weight-stationary PE array. It loads 16 weight columns through a valid/ready stream, then streams a programmed number of 16-byte input vectors into the array. It tracks each vector through the array's 16-row skew and accumulation pipeline and tags the bottom-row partial sums with valid/last. It also guarantees that weights never change while any vector is still in flight.

## Interface
- ARRAY_DIM, 16, array dimension; fixed at 16, weight_col is 4 bits
- DATA_WIDTH, 8, input/weight element width
- ACC_WIDTH, 32, partial-sum width
- CNT_WIDTH, 16, width of the vector count
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- reuse_weights  in  1  sampled with start; 1 = skip LOAD_W
- num_vectors  in  CNT_WIDTH  vectors in the job; latched at start
- w_valid / w_ready  in / out  1 / 1  weight-column stream handshake
- w_data  in  ARRAY_DIM*DATA_WIDTH  one column, byte r goes to row r
- d_valid / d_ready  in / out  1 / 1  input-vector stream handshake
- d_data  in  ARRAY_DIM*DATA_WIDTH  one vector, byte r is input channel r
- weight_write_enable  out  1  to array
- weight_col  out  4  to array
- weight_in  out  ARRAY_DIM*DATA_WIDTH  to array
- data_in  out  ARRAY_DIM*DATA_WIDTH  to array
- psum_out  in  ARRAY_DIM*ACC_WIDTH  from array bottom row
- res_valid  out  1  res_data holds a valid result
- res_last  out  1  result of the final vector of the job
- res_data  out  ARRAY_DIM*ACC_WIDTH  psum_out passed through combinationally
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on start, or -> STREAM if reuse_weights=1. num_vectors is latched on this transition.
- LOAD_W:
  - w_ready=1.
  - Each handshake registers weight_write_enable=1, weight_col=col_cnt, weight_in=w_data for exactly one cycle.
  - col_cnt counts 0..15.
  - After the 16th beat the FSM goes to STREAM, or to DONE if the latched count is 0.
- STREAM:
  - d_ready=1 while accepted count < latched count.
  - Each handshake registers data_in=d_data and shifts a 1 into a 17-stage valid pipeline.
  - Cycles without a handshake drive data_in=0 and shift a 0 in (bubble).
  - After the last accept the FSM goes to DRAIN.
- STREAM with count 0 (reuse_weights=1, num_vectors=0): the FSM goes directly to DONE.
- DRAIN:
  - d_ready=0.
  - Stays in DRAIN until the valid pipeline is all zero, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- res_valid is the output of the last valid-pipeline stage.
- res_last = res_valid and the result index equals the latched count minus 1.
- w_ready is 0 outside LOAD_W. d_ready is 0 outside STREAM.
- start is ignored when not in IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - All counters and the valid pipeline cleared.
  - w_ready=d_ready=weight_write_enable=res_valid=res_last=busy=done=0.
  - weight_col=0, weight_in=0, data_in=0.
- Reset takes effect on the next clock edge from any state. A partial weight load leaves array weights partially updated; the controller does not clear array weights.
- Weight write: handshake at edge k -> weight_write_enable high during cycle k+1.
- Vector latency: handshake at edge k -> data_in valid in cycle k+1 -> res_valid with the matching psum in cycle k+17.
- Gap-free input gives one result per cycle.
- Bubbles shift results by the same number of cycles; result order is preserved.
- Full job, no stalls, N>0:
  - start at edge s, busy from cycle s+1.
  - 16 weight beats.
  - N stream cycles.
  - Last result at cycle (last accept)+17.
  - done in the following cycle.
- Weights never change while a valid vector is in flight, because LOAD_W is reachable only from IDLE.

## Configuration
- PE_ARRAY_CTRL_PERF_EN defined:
  - Adds outputs stall_cycles and job_cycles (32-bit each).
  - stall_cycles counts STREAM cycles with d_ready=1 and d_valid=0.
  - job_cycles counts cycles with busy=1.
  - Both clear at start acceptance and hold after DONE; both saturate at all-ones.
  - Both reset to 0.
- Undefined: no counters and no extra ports.

## Test plan
- Load weights W[c][r]=c+r, stream 4 vectors with element r = r+1 -> 16 write pulses with weight_col 0..15; res_valid 4 consecutive cycles starting 17 cycles after the first accept; res_last only on the 4th; done pulse after it.
- reuse_weights=1, num_vectors=3 -> no weight_write_enable; first res_valid 17 cycles after the first accept.
- Stream 3 vectors with d_valid low 2 cycles between vectors 1 and 2 -> data_in=0 in the bubble cycles; the result of vector 2 arrives 2 cycles later than in the gap-free case; 3 res_valid pulses total.
- num_vectors=0, reuse_weights=0 -> 16 weight beats, no res_valid, DONE immediately after LOAD_W.
- rst asserted mid-STREAM after 2 of 5 accepts -> next cycle all outputs at reset values and FSM in IDLE; no res_valid afterward; a new job completes normally.
- start pulsed while busy -> ignored; the job completes unchanged.

Source files
------------

// File: rtl/pe_array_ctrl_if.sv
// Weight-column and input-vector stream handshakes between a feeder (master) and
// the PE array sequencer (slave).
interface pe_array_ctrl_if #(
    parameter int ARRAY_DIM  = 16,
    parameter int DATA_WIDTH = 8
);
    logic                            w_valid;
    logic                            w_ready;
    logic [ARRAY_DIM*DATA_WIDTH-1:0] w_data;
    logic                            d_valid;
    logic                            d_ready;
    logic [ARRAY_DIM*DATA_WIDTH-1:0] d_data;

    modport master (
        output w_valid, w_data, d_valid, d_data,
        input  w_ready, d_ready
    );

    modport slave (
        input  w_valid, w_data, d_valid, d_data,
        output w_ready, d_ready
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for the 16x16 weight-stationary PE array: weight load, vector streaming,
// result tagging across the 17-cycle array pipeline. Optional counters: PE_ARRAY_CTRL_PERF_EN.
module pe_array_ctrl #(
    parameter int ARRAY_DIM  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    pe_array_ctrl_if.slave                  strm,
    input  logic                            start_i,
    input  logic                            reuse_weights_i,
    input  logic [CNT_WIDTH-1:0]            num_vectors_i,
    output logic                            weight_write_enable_o,
    output logic [3:0]                      weight_col_o,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] weight_in_o,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] data_in_o,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  psum_out_i,
    output logic                            res_valid_o,
    output logic                            res_last_o,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0]  res_data_o,
    output logic                            busy_o,
    output logic                            done_o
`ifdef PE_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]                     stall_cycles_o,
    output logic [31:0]                     job_cycles_o
`endif
);
    localparam int PIPE = ARRAY_DIM + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

    state_e                            state_q, state_d;
    logic [CNT_WIDTH-1:0]              num_q;
    logic [CNT_WIDTH-1:0]              acc_cnt_q;
    logic [CNT_WIDTH-1:0]              res_cnt_q;
    logic [3:0]                        col_cnt_q;
    logic [PIPE-1:0]                   vld_q;
    logic                              wwe_q;
    logic [3:0]                        wcol_q;
    logic [ARRAY_DIM*DATA_WIDTH-1:0]   win_q;
    logic [ARRAY_DIM*DATA_WIDTH-1:0]   din_q;

    logic w_hs, d_hs, job_start;

    assign w_hs      = strm.w_valid && strm.w_ready;
    assign d_hs      = strm.d_valid && strm.d_ready;
    assign job_start = (state_q == IDLE) && start_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_i) state_d = reuse_weights_i ? STREAM : LOAD_W;
            LOAD_W: if (w_hs && col_cnt_q == 4'(ARRAY_DIM - 1))
                        state_d = (num_q == '0) ? DONE : STREAM;
            STREAM: begin
                if (num_q == '0)
                    state_d = DONE;
                else if (d_hs && acc_cnt_q == num_q - 1'b1)
                    state_d = DRAIN;
            end
            // The bottom stage leaves this cycle, so only the upper stages must be empty.
            DRAIN:  if (vld_q[PIPE-2:0] == '0) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strm.w_ready = 1'b0;
        strm.d_ready = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            LOAD_W: begin strm.w_ready = 1'b1; busy_o = 1'b1; end
            STREAM: begin strm.d_ready = (acc_cnt_q < num_q); busy_o = 1'b1; end
            DRAIN:  busy_o = 1'b1;
            DONE:   done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            acc_cnt_q <= '0;
            res_cnt_q <= '0;
            col_cnt_q <= '0;
            vld_q     <= '0;
            wwe_q     <= 1'b0;
            wcol_q    <= '0;
            win_q     <= '0;
            din_q     <= '0;
        end else begin
            vld_q <= {vld_q[PIPE-2:0], d_hs};
            wwe_q <= w_hs;
            din_q <= d_hs ? strm.d_data : '0;
            if (w_hs) begin
                wcol_q    <= col_cnt_q;
                win_q     <= strm.w_data;
                col_cnt_q <= col_cnt_q + 1'b1;
            end
            if (d_hs)        acc_cnt_q <= acc_cnt_q + 1'b1;
            if (res_valid_o) res_cnt_q <= res_cnt_q + 1'b1;
            if (job_start) begin
                num_q     <= num_vectors_i;
                acc_cnt_q <= '0;
                res_cnt_q <= '0;
                col_cnt_q <= '0;
            end
        end
    end

    assign weight_write_enable_o = wwe_q;
    assign weight_col_o          = wcol_q;
    assign weight_in_o           = win_q;
    assign data_in_o             = din_q;
    assign res_valid_o           = vld_q[PIPE-1];
    assign res_last_o            = vld_q[PIPE-1] && (res_cnt_q == num_q - 1'b1);
    assign res_data_o            = psum_out_i;

`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] stall_q, job_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            job_q   <= '0;
        end else if (job_start) begin
            stall_q <= '0;
            job_q   <= '0;
        end else begin
            if (busy_o && job_q != '1) job_q <= job_q + 1'b1;
            if (state_q == STREAM && strm.d_ready && !strm.d_valid && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign job_cycles_o   = job_q;
`endif
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: weight load, streaming latency, bubbles, zero-length jobs, reset, start while busy.
module tb_pe_array_ctrl;
    localparam int AD = 16;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int CW = 16;

    logic clk;
    logic rst;
    logic start, reuse;
    logic [CW-1:0] num;
    logic [AD*AW-1:0] psum;
    logic wwe_o, res_valid_o, res_last_o, busy_o, done_o;
    logic [3:0] weight_col_o;
    logic [AD*DW-1:0] weight_in_o, data_in_o;
    logic [AD*AW-1:0] res_data_o;
`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] stall_cycles_o, job_cycles_o;
`endif

    pe_array_ctrl_if #(.ARRAY_DIM(AD), .DATA_WIDTH(DW)) bus ();

    pe_array_ctrl #(.ARRAY_DIM(AD), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .strm                  (bus),
        .start_i               (start),
        .reuse_weights_i       (reuse),
        .num_vectors_i         (num),
        .weight_write_enable_o (wwe_o),
        .weight_col_o          (weight_col_o),
        .weight_in_o           (weight_in_o),
        .data_in_o             (data_in_o),
        .psum_out_i            (psum),
        .res_valid_o           (res_valid_o),
        .res_last_o            (res_last_o),
        .res_data_o            (res_data_o),
        .busy_o                (busy_o),
        .done_o                (done_o)
`ifdef PE_ARRAY_CTRL_PERF_EN
        ,
        .stall_cycles_o        (stall_cycles_o),
        .job_cycles_o          (job_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [AD*DW-1:0] wcol(input int c);
        logic [AD*DW-1:0] v;
        for (int r = 0; r < AD; r++) v[r*DW +: DW] = 8'(c + r);
        return v;
    endfunction

    function automatic logic [AD*DW-1:0] vec(input int i);
        logic [AD*DW-1:0] v;
        for (int r = 0; r < AD; r++) v[r*DW +: DW] = 8'(r + 1 + 16 * i);
        return v;
    endfunction

    // Event log, written only by the monitor; tests compare deltas against snapshots.
    int cyc = 0;
    int wwe_cnt = 0, col_err = 0, win_err = 0, din_err = 0, last_wwe_cyc = 0;
    int acc_cnt = 0, rv_cnt = 0, rl_cnt = 0, rl_cyc = 0, done_cnt = 0, done_cyc = 0;
    int acc_cyc[64];
    int rv_cyc[64];
    logic prev_hs = 1'b0;
    logic [AD*DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wwe_o) begin
            if (weight_col_o !== wwe_cnt[3:0]) col_err++;
            if (weight_in_o !== wcol(wwe_cnt % 16)) win_err++;
            wwe_cnt++;
            last_wwe_cyc = cyc;
        end
        if (prev_hs ? (data_in_o !== prev_data) : (data_in_o !== '0)) din_err++;
        prev_hs   = bus.d_valid && bus.d_ready && !rst;
        prev_data = bus.d_data;
        if (prev_hs) begin
            if (acc_cnt < 64) acc_cyc[acc_cnt] = cyc;
            acc_cnt++;
        end
        if (res_valid_o) begin
            if (rv_cnt < 64) rv_cyc[rv_cnt] = cyc;
            rv_cnt++;
        end
        if (res_last_o) begin rl_cnt++; rl_cyc = cyc; end
        if (done_o)     begin done_cnt++; done_cyc = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic rw, input int n);
        start = 1'b1; reuse = rw; num = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic load_weights(input string tag);
        int c = 0;
        int g = 0;
        logic hs;
        bus.w_valid = 1'b1;
        while (c < 16 && g < 100) begin
            bus.w_data = wcol(c);
            hs = bus.w_ready;
            tick();
            g++;
            if (hs) c++;
        end
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        check({tag, "_wload_to"}, 64'(c), 64'd16);
    endtask

    task automatic send_vectors(input string tag, input int n, input int gap_at, input int gap_len);
        int s = 0;
        int g = 0;
        int gap = 0;
        logic hs;
        while (s < n && g < 200) begin
            if (gap > 0) begin
                bus.d_valid = 1'b0; bus.d_data = '0;
            end else begin
                bus.d_valid = 1'b1; bus.d_data = vec(s);
            end
            hs = bus.d_valid && bus.d_ready;
            tick();
            g++;
            if (gap > 0) gap--;
            else if (hs) begin
                s++;
                if (s == gap_at) gap = gap_len;
            end
        end
        bus.d_valid = 1'b0;
        bus.d_data  = '0;
        check({tag, "_send_to"}, 64'(s), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!done_o && g < 300) begin tick(); g++; end
        check({tag, "_done_seen"}, 64'(done_o), 64'd1);
        tick();
        check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int wb, ab, rb, lb, db;

    initial begin
        rst = 1'b1; start = 1'b0; reuse = 1'b0; num = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.d_valid = 1'b0; bus.d_data = '0;
        for (int l = 0; l < AD; l++) psum[l*AW +: AW] = 32'hA500_0000 + 32'(l * 3);
        tick(); tick();

        // Reset state
        check("rst_busy",   64'(busy_o), 0);
        check("rst_done",   64'(done_o), 0);
        check("rst_wready", 64'(bus.w_ready), 0);
        check("rst_dready", 64'(bus.d_ready), 0);
        check("rst_wwe",    64'(wwe_o), 0);
        check("rst_rvalid", 64'(res_valid_o), 0);
        check("rst_rlast",  64'(res_last_o), 0);
        check("rst_wcol",   64'(weight_col_o), 0);
        check("rst_win",    64'(weight_in_o == '0), 1);
        check("rst_din",    64'(data_in_o == '0), 1);
        check("res_data_passthru", 64'(res_data_o == psum), 1);
        rst = 1'b0;
        tick();

        // Full job: 16 weight beats, 4 vectors
        wb = wwe_cnt; ab = acc_cnt; rb = rv_cnt; lb = rl_cnt; db = din_err;
        start_job(1'b0, 4);
        check("t1_busy_s1",  64'(busy_o), 1);
        check("t1_wready",   64'(bus.w_ready), 1);
        load_weights("t1");
        send_vectors("t1", 4, -1, 0);
        wait_done("t1");
        check("t1_wwe_cnt",  64'(wwe_cnt - wb), 16);
        check("t1_col_err",  64'(col_err), 0);
        check("t1_win_err",  64'(win_err), 0);
        check("t1_rv_cnt",   64'(rv_cnt - rb), 4);
        check("t1_latency",  64'(rv_cyc[rb] - acc_cyc[ab]), 17);
        check("t1_rv_span",  64'(rv_cyc[rb+3] - rv_cyc[rb]), 3);
        check("t1_rl_cnt",   64'(rl_cnt - lb), 1);
        check("t1_rl_pos",   64'(rl_cyc - rv_cyc[rb+3]), 0);
        check("t1_done_pos", 64'(done_cyc - rv_cyc[rb+3]), 1);
        check("t1_din_err",  64'(din_err - db), 0);

        // Reuse weights, 3 vectors
        wb = wwe_cnt; ab = acc_cnt; rb = rv_cnt; lb = rl_cnt;
        start_job(1'b1, 3);
        check("t2_wready",   64'(bus.w_ready), 0);
        check("t2_dready",   64'(bus.d_ready), 1);
        send_vectors("t2", 3, -1, 0);
        wait_done("t2");
        check("t2_wwe_cnt",  64'(wwe_cnt - wb), 0);
        check("t2_rv_cnt",   64'(rv_cnt - rb), 3);
        check("t2_latency",  64'(rv_cyc[rb] - acc_cyc[ab]), 17);
        check("t2_rl_cnt",   64'(rl_cnt - lb), 1);

        // Two-cycle bubble between vectors 1 and 2
        ab = acc_cnt; rb = rv_cnt; lb = rl_cnt; db = din_err;
        start_job(1'b1, 3);
        send_vectors("t3", 3, 1, 2);
        wait_done("t3");
        check("t3_rv_cnt",   64'(rv_cnt - rb), 3);
        check("t3_gap01",    64'(rv_cyc[rb+1] - rv_cyc[rb]), 3);
        check("t3_gap12",    64'(rv_cyc[rb+2] - rv_cyc[rb+1]), 1);
        check("t3_lat1",     64'(rv_cyc[rb+1] - acc_cyc[ab+1]), 17);
        check("t3_din_err",  64'(din_err - db), 0);
        check("t3_rl_pos",   64'(rl_cyc - rv_cyc[rb+2]), 0);

        // Zero vectors with weight load
        wb = wwe_cnt; rb = rv_cnt;
        start_job(1'b0, 0);
        load_weights("t4");
        wait_done("t4");
        check("t4_wwe_cnt",  64'(wwe_cnt - wb), 16);
        check("t4_rv_cnt",   64'(rv_cnt - rb), 0);
        check("t4_done_pos", 64'(done_cyc - last_wwe_cyc), 0);

        // Reset mid-STREAM after 2 of 5 accepts
        start_job(1'b1, 5);
        send_vectors("t5", 2, -1, 0);
        rst = 1'b1;
        tick();
        check("t5_busy",   64'(busy_o), 0);
        check("t5_dready", 64'(bus.d_ready), 0);
        check("t5_rvalid", 64'(res_valid_o), 0);
        check("t5_din",    64'(data_in_o == '0), 1);
        check("t5_wcol",   64'(weight_col_o), 0);
        check("t5_win",    64'(weight_in_o == '0), 1);
        rst = 1'b0;
        rb = rv_cnt;
        for (int i = 0; i < 30; i++) tick();
        check("t5_no_rv",  64'(rv_cnt - rb), 0);
        rb = rv_cnt; lb = rl_cnt;
        start_job(1'b1, 2);
        send_vectors("t5b", 2, -1, 0);
        wait_done("t5b");
        check("t5b_rv_cnt", 64'(rv_cnt - rb), 2);
        check("t5b_rl_cnt", 64'(rl_cnt - lb), 1);

        // start pulsed while busy is ignored
        wb = wwe_cnt; rb = rv_cnt; lb = rl_cnt;
        start_job(1'b1, 3);
        start = 1'b1; reuse = 1'b0; num = CW'(9);
        tick();
        start = 1'b0;
        send_vectors("t6", 3, -1, 0);
        wait_done("t6");
        check("t6_rv_cnt",  64'(rv_cnt - rb), 3);
        check("t6_wwe_cnt", 64'(wwe_cnt - wb), 0);
        check("t6_rl_cnt",  64'(rl_cnt - lb), 1);
        check("t6_rl_pos",  64'(rl_cyc - rv_cyc[rb+2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
